// File: rtl/ecc_s1d_decoder.sv
// rtl/ecc_s1d_decoder.sv - two-stage S1D codeword decoder with error counters and first-error log
// Stage 1 computes the syndrome; stage 2 corrects and flags; both shift together on adv.
module ecc_s1d_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [37:0]      EDI,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [31:0]      EDO,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             ERR_CE,
  output logic             ERR_UE,
  output logic [5:0]       SYN,
  input  logic             CLR_CNT,
  output logic [CNT_W-1:0] CE_CNT,
  output logic [CNT_W-1:0] UE_CNT,
  output logic             LOG_VALID,
  output logic [5:0]       LOG_SYN,
  output logic             LOG_UE
);

  function automatic logic [5:0] d_col(input int i);
    case (i)
      0:  d_col = 6'h03;  1:  d_col = 6'h05;  2:  d_col = 6'h06;  3:  d_col = 6'h07;
      4:  d_col = 6'h09;  5:  d_col = 6'h0A;  6:  d_col = 6'h0B;  7:  d_col = 6'h0C;
      8:  d_col = 6'h0D;  9:  d_col = 6'h0E;  10: d_col = 6'h11;  11: d_col = 6'h12;
      12: d_col = 6'h13;  13: d_col = 6'h14;  14: d_col = 6'h15;  15: d_col = 6'h16;
      16: d_col = 6'h18;  17: d_col = 6'h19;  18: d_col = 6'h1A;  19: d_col = 6'h21;
      20: d_col = 6'h22;  21: d_col = 6'h24;  22: d_col = 6'h26;  23: d_col = 6'h28;
      24: d_col = 6'h29;  25: d_col = 6'h2A;  26: d_col = 6'h2C;  27: d_col = 6'h30;
      28: d_col = 6'h31;  29: d_col = 6'h32;  30: d_col = 6'h34;  31: d_col = 6'h38;
      default: d_col = 6'h00;
    endcase
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_data_q, s1_data_d;
  logic [5:0]       s1_syn_q, s1_syn_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      edo_q, edo_d;
  logic             ce_q, ce_d;
  logic             ue_q, ue_d;
  logic [5:0]       syn_q, syn_d;
  logic [CNT_W-1:0] ce_cnt_q, ce_cnt_d;
  logic [CNT_W-1:0] ue_cnt_q, ue_cnt_d;
  logic             log_valid_q, log_valid_d;
  logic [5:0]       log_syn_q, log_syn_d;
  logic             log_ue_q, log_ue_d;

  logic        adv;
  logic        xfer;
  logic [31:0] in_data;
  logic [5:0]  in_syn;
  logic [31:0] flip;
  logic        dec_ce;
  logic        dec_ue;

  assign adv  = !out_valid_q || OUT_READY;
  assign xfer = out_valid_q && OUT_READY;
  assign in_data = {EDI[37:25], EDI[23:15], EDI[13:8], EDI[6:4], EDI[2]};

  always_comb begin
    in_syn = {EDI[24], EDI[14], EDI[7], EDI[3], EDI[1], EDI[0]};
    for (int i = 0; i < 32; i++) begin
      if (in_data[i]) in_syn = in_syn ^ d_col(i);
    end
  end

  // A parity-column syndrome is correctable but leaves data untouched.
  always_comb begin
    flip = '0;
    for (int i = 0; i < 32; i++) begin
      if (s1_syn_q == d_col(i)) flip[i] = 1'b1;
    end
    dec_ce = (|flip) || $onehot(s1_syn_q);
    dec_ue = (s1_syn_q != 6'h00) && !dec_ce;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_syn_d    = s1_syn_q;
    out_valid_d = out_valid_q;
    edo_d       = edo_q;
    ce_d        = ce_q;
    ue_d        = ue_q;
    syn_d       = syn_q;
    if (adv) begin
      s1_valid_d  = IN_VALID;
      s1_data_d   = in_data;
      s1_syn_d    = in_syn;
      out_valid_d = s1_valid_q;
      edo_d       = s1_data_q ^ flip;
      ce_d        = s1_valid_q && dec_ce;
      ue_d        = s1_valid_q && dec_ue;
      syn_d       = s1_syn_q;
    end
  end

  // Clear takes priority over a coincident error transfer.
  always_comb begin
    ce_cnt_d    = ce_cnt_q;
    ue_cnt_d    = ue_cnt_q;
    log_valid_d = log_valid_q;
    log_syn_d   = log_syn_q;
    log_ue_d    = log_ue_q;
    if (CLR_CNT) begin
      ce_cnt_d    = '0;
      ue_cnt_d    = '0;
      log_valid_d = 1'b0;
      log_syn_d   = 6'h00;
      log_ue_d    = 1'b0;
    end else if (xfer) begin
      if (ce_q && (ce_cnt_q != {CNT_W{1'b1}})) ce_cnt_d = ce_cnt_q + CNT_W'(1);
      if (ue_q && (ue_cnt_q != {CNT_W{1'b1}})) ue_cnt_d = ue_cnt_q + CNT_W'(1);
      if ((ce_q || ue_q) && !log_valid_q) begin
        log_valid_d = 1'b1;
        log_syn_d   = syn_q;
        log_ue_d    = ue_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_syn_q    <= '0;
      out_valid_q <= 1'b0;
      edo_q       <= '0;
      ce_q        <= 1'b0;
      ue_q        <= 1'b0;
      syn_q       <= '0;
      ce_cnt_q    <= '0;
      ue_cnt_q    <= '0;
      log_valid_q <= 1'b0;
      log_syn_q   <= '0;
      log_ue_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_syn_q    <= s1_syn_d;
      out_valid_q <= out_valid_d;
      edo_q       <= edo_d;
      ce_q        <= ce_d;
      ue_q        <= ue_d;
      syn_q       <= syn_d;
      ce_cnt_q    <= ce_cnt_d;
      ue_cnt_q    <= ue_cnt_d;
      log_valid_q <= log_valid_d;
      log_syn_q   <= log_syn_d;
      log_ue_q    <= log_ue_d;
    end
  end

  assign IN_READY  = adv;
  assign OUT_VALID = out_valid_q;
  assign EDO       = edo_q;
  assign ERR_CE    = ce_q;
  assign ERR_UE    = ue_q;
  assign SYN       = syn_q;
  assign CE_CNT    = ce_cnt_q;
  assign UE_CNT    = ue_cnt_q;
  assign LOG_VALID = log_valid_q;
  assign LOG_SYN   = log_syn_q;
  assign LOG_UE    = log_ue_q;

endmodule
